crack_ctrl: RTL and testbench

- Parametrised top-level control FSM for the ARC4 key cracker.
- Drives NUM_CH cracker cores over the en/rdy/key/key_valid handshake and assigns each core its key-space base.
- Latches the first valid key found and produces packed 5-bit display codes for the seven-segment decoders.
- Sits between the board I/O (start button, HEX digits) and the cracker instances.

---
 rtl/crack_pkg.sv | 32 +++
 rtl/crack_digit_mux.sv | 31 +++
 rtl/crack_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_crack_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crack_pkg.sv
// Shared types, display codes and the lowest-index picker for the ARC4 crack controller.
package crack_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        ARM      = 3'd2,
        CRACK    = 3'd3,
        DONE     = 3'd4
    } state_e;

    localparam int MAX_CH = 16;

    localparam logic [4:0] SEG_BLANK = 5'd16;
    localparam logic [4:0] SEG_DASH  = 5'd17;
    localparam logic [4:0] SEG_ERR   = 5'd18;

    // Scanning downwards leaves the lowest set index as the final answer.
    function automatic logic [3:0] priority_pick(input logic [MAX_CH-1:0] valid);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (valid[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/crack_digit_mux.sv
// Maps the latched result and run status onto packed 5-bit seven-segment codes.
module crack_digit_mux
    import crack_pkg::*;
#(
    parameter int KEY_W  = 24,
    parameter int DIGITS = KEY_W / 4
) (
    input  logic [KEY_W-1:0]    result_key,
    input  logic                busy,
    input  logic                found,
    input  logic                timed_out,
    output logic [DIGITS*5-1:0] digit_codes
);

    // Status overrides the key: dashes while running, E after a timeout.
    always_comb begin
        digit_codes = {DIGITS{SEG_BLANK}};
        for (int d = 0; d < DIGITS; d++) begin
            if (busy) begin
                digit_codes[d*5 +: 5] = SEG_DASH;
            end else if (timed_out) begin
                digit_codes[d*5 +: 5] = SEG_ERR;
            end else if (found) begin
                digit_codes[d*5 +: 5] = {1'b0, result_key[d*4 +: 4]};
            end else begin
                digit_codes[d*5 +: 5] = SEG_BLANK;
            end
        end
    end

endmodule

// File: rtl/crack_ctrl.sv
// Top-level control FSM for the multi-channel ARC4 key cracker.
// Define CRACK_TIMEOUT_EN to bound the crack phase to TIMEOUT_CYCLES cycles.
module crack_ctrl
    import crack_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int KEY_W          = 24,
    parameter int DIGITS         = KEY_W / 4,
    parameter int TIMEOUT_CYCLES = 2**26
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       ch_rdy,
    input  logic [NUM_CH*KEY_W-1:0] ch_key,
    input  logic [NUM_CH-1:0]       ch_key_valid,
    output logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH*KEY_W-1:0] ch_key_base,
    output logic                    busy,
    output logic                    result_valid,
    output logic                    found,
    output logic [KEY_W-1:0]        result_key,
    output logic                    timed_out,
    output logic [DIGITS*5-1:0]     digit_codes
);

    localparam longint unsigned KEY_SPAN = (64'd1 << KEY_W) / 64'(NUM_CH);

    state_e             state_q, state_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               result_valid_q, result_valid_d;
    logic               found_q, found_d;
    logic [KEY_W-1:0]   result_key_q, result_key_d;
    logic               timed_out_q, timed_out_d;

    logic [NUM_CH-1:0]  ch_en_s;
    logic [NUM_CH-1:0]  hit_s;
    logic [MAX_CH-1:0]  hit_ext_s;
    logic [3:0]         pick_idx_s;
    logic [KEY_W-1:0]   pick_key_s;
    logic               trigger_s;
    logic               all_rdy_s;
    logic               timeout_s;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_base
            assign ch_key_base[g*KEY_W +: KEY_W] = KEY_W'(KEY_SPAN * 64'(g));
        end
    endgenerate

    assign trigger_s  = start & ~start_q;
    assign all_rdy_s  = &ch_rdy;
    assign hit_s      = ch_rdy & ch_key_valid;
    assign hit_ext_s  = MAX_CH'(hit_s);
    assign pick_idx_s = priority_pick(hit_ext_s);

    // Select the key slice of the winning channel.
    always_comb begin
        pick_key_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (4'(i) == pick_idx_s) begin
                pick_key_s = ch_key[i*KEY_W +: KEY_W];
            end else begin
                pick_key_s = pick_key_s;
            end
        end
    end

`ifdef CRACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Crack-phase cycle counter, restarted as the cores are enabled.
    always_comb begin
        if ((state_q == WAIT_RDY) && all_rdy_s) begin
            cnt_d = '0;
        end else if (state_q == CRACK) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_s = (state_q == CRACK) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and result logic; ch_en fires in the same cycle all cores report ready.
    always_comb begin
        state_d        = state_q;
        result_valid_d = result_valid_q;
        found_d        = found_q;
        result_key_d   = result_key_q;
        timed_out_d    = timed_out_q;
        ch_en_s        = '0;
        case (state_q)
            IDLE, DONE: begin
                if (trigger_s) begin
                    state_d        = WAIT_RDY;
                    result_valid_d = 1'b0;
                    found_d        = 1'b0;
                    timed_out_d    = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            WAIT_RDY: begin
                if (all_rdy_s) begin
                    ch_en_s = '1;
                    state_d = ARM;
                end else begin
                    state_d = WAIT_RDY;
                end
            end
            ARM: begin
                state_d = CRACK;
            end
            CRACK: begin
                if (|hit_s) begin
                    state_d        = DONE;
                    result_key_d   = pick_key_s;
                    found_d        = 1'b1;
                    result_valid_d = 1'b1;
                end else if (all_rdy_s) begin
                    state_d        = DONE;
                    found_d        = 1'b0;
                    result_valid_d = 1'b1;
                end else if (timeout_s) begin
                    state_d        = DONE;
                    found_d        = 1'b0;
                    timed_out_d    = 1'b1;
                    result_valid_d = 1'b1;
                end else begin
                    state_d = CRACK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == WAIT_RDY) || (state_d == ARM) || (state_d == CRACK);
        start_d = start;
    end

    // State and output registers; start_q resets high so a held button cannot trigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            start_q        <= 1'b1;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            found_q        <= 1'b0;
            result_key_q   <= '0;
            timed_out_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            found_q        <= found_d;
            result_key_q   <= result_key_d;
            timed_out_q    <= timed_out_d;
        end
    end

    assign ch_en        = rst ? '0 : ch_en_s;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign found        = found_q;
    assign result_key   = result_key_q;
    assign timed_out    = timed_out_q;

    crack_digit_mux #(
        .KEY_W  (KEY_W),
        .DIGITS (DIGITS)
    ) u_digit_mux (
        .result_key  (result_key_q),
        .busy        (busy_q),
        .found       (found_q),
        .timed_out   (timed_out_q),
        .digit_codes (digit_codes)
    );

endmodule

// File: tb/tb_crack_ctrl.sv
// Self-checking bench for crack_ctrl: emulated cracker cores plus a result model.
module tb_crack_ctrl;

    localparam int NUM_CH = 4;
    localparam int KEY_W  = 24;
    localparam int DIGITS = KEY_W / 4;
    localparam int TO_CYC = 100;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [NUM_CH-1:0]       ch_rdy;
    logic [NUM_CH*KEY_W-1:0] ch_key;
    logic [NUM_CH-1:0]       ch_key_valid;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH*KEY_W-1:0] ch_key_base;
    logic                    busy;
    logic                    result_valid;
    logic                    found;
    logic [KEY_W-1:0]        result_key;
    logic                    timed_out;
    logic [DIGITS*5-1:0]     digit_codes;

    int checks = 0;
    int passes = 0;

    // Job description for the emulated cores: dly 0 means the core never finishes.
    int               job_dly [NUM_CH];
    logic             job_vld [NUM_CH];
    logic [KEY_W-1:0] job_key [NUM_CH];

    crack_ctrl #(
        .NUM_CH         (NUM_CH),
        .KEY_W          (KEY_W),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ch_rdy       (ch_rdy),
        .ch_key       (ch_key),
        .ch_key_valid (ch_key_valid),
        .ch_en        (ch_en),
        .ch_key_base  (ch_key_base),
        .busy         (busy),
        .result_valid (result_valid),
        .found        (found),
        .result_key   (result_key),
        .timed_out    (timed_out),
        .digit_codes  (digit_codes)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DIGITS*5-1:0] exp_digits(input logic b, input logic f,
                                                       input logic t, input logic [KEY_W-1:0] k);
        logic [DIGITS*5-1:0] v;
        for (int d = 0; d < DIGITS; d++) begin
            if (b)      v[d*5 +: 5] = 5'd17;
            else if (t) v[d*5 +: 5] = 5'd18;
            else if (f) v[d*5 +: 5] = {1'b0, k[d*4 +: 4]};
            else        v[d*5 +: 5] = 5'd16;
        end
        return v;
    endfunction

    task automatic run_job(input string name);
        int best, t_fin, done_cyc;
        logic exp_found;
        logic [KEY_W-1:0] exp_key;
        bit got;
        best = -1;
        t_fin = 0;
        exp_key = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (job_vld[i] && job_dly[i] > 0 && (best < 0 || job_dly[i] < job_dly[best])) best = i;
        if (best >= 0) begin
            exp_found = 1'b1;
            exp_key   = job_key[best];
            t_fin     = job_dly[best];
        end else begin
            exp_found = 1'b0;
            for (int i = 0; i < NUM_CH; i++) if (job_dly[i] > t_fin) t_fin = job_dly[i];
        end
        @(negedge clk);
        start = 1'b0;
        ch_rdy = '1;
        ch_key_valid = '0;
        for (int i = 0; i < NUM_CH; i++) ch_key[i*KEY_W +: KEY_W] = KEY_W'($urandom);
        @(negedge clk);
        start = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            #1;
            if (ch_en == {NUM_CH{1'b1}}) got = 1'b1;
        end
        checks++;
        if (!got) begin
            $display("FAIL %s en_pulse: got none expected %b", name, {NUM_CH{1'b1}});
            return;
        end else passes++;
        checks++;
        if ({busy, result_valid, found, digit_codes} !== {1'b1, 1'b0, 1'b0, exp_digits(1'b1, 1'b0, 1'b0, '0)})
            $display("FAIL %s busy_state: got %b%b%b %h expected 100 %h", name, busy, result_valid,
                     found, digit_codes, exp_digits(1'b1, 1'b0, 1'b0, '0));
        else passes++;
        @(posedge clk);
        #1;
        ch_rdy = '0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (ch_en !== '0) $display("FAIL %s en_width: got %b expected 0", name, ch_en);
        else passes++;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 400 && done_cyc == 0; cyc++) begin
            @(posedge clk);
            #1;
            if (result_valid) done_cyc = cyc;
            else
                for (int i = 0; i < NUM_CH; i++)
                    if (job_dly[i] == cyc) begin
                        ch_rdy[i] = 1'b1;
                        ch_key_valid[i] = job_vld[i];
                        ch_key[i*KEY_W +: KEY_W] = job_key[i];
                    end
        end
        checks++;
        if (done_cyc != t_fin + 1) $display("FAIL %s done_latency: got %0d expected %0d", name, done_cyc, t_fin + 1);
        else passes++;
        checks++;
        if ({busy, found, timed_out} !== {1'b0, exp_found, 1'b0})
            $display("FAIL %s flags: got busy=%b found=%b to=%b expected 0 %b 0", name, busy, found, timed_out, exp_found);
        else passes++;
        if (exp_found) begin
            checks++;
            if (result_key !== exp_key) $display("FAIL %s result_key: got %h expected %h", name, result_key, exp_key);
            else passes++;
        end
        checks++;
        if (digit_codes !== exp_digits(1'b0, exp_found, 1'b0, exp_key))
            $display("FAIL %s digits: got %h expected %h", name, digit_codes, exp_digits(1'b0, exp_found, 1'b0, exp_key));
        else passes++;
        @(negedge clk);
        ch_rdy = '1;
        ch_key_valid = '0;
    endtask

    task automatic test_reset();
        int en_cnt, busy_cnt;
        bit width_ok;
        rst = 1'b1;
        start = 1'b1;
        ch_rdy = '1;
        ch_key_valid = '0;
        ch_key = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({ch_en, busy, result_valid, found, result_key, timed_out} !== '0 ||
            digit_codes !== {DIGITS{5'd16}})
            $display("FAIL reset_values: got en=%b busy=%b rv=%b f=%b key=%h to=%b dig=%h expected zeros/blank",
                     ch_en, busy, result_valid, found, result_key, timed_out, digit_codes);
        else passes++;
        rst = 1'b0;
        en_cnt = 0;
        busy_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (ch_en !== '0) en_cnt++;
            if (busy) busy_cnt++;
        end
        checks++;
        if (en_cnt + busy_cnt != 0) $display("FAIL held_start: got en=%0d busy=%0d expected 0 0", en_cnt, busy_cnt);
        else passes++;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        en_cnt = 0;
        width_ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            #1;
            if (ch_en !== '0) begin
                en_cnt++;
                if (ch_en !== {NUM_CH{1'b1}}) width_ok = 1'b0;
            end
        end
        checks++;
        if (en_cnt != 1 || !width_ok) $display("FAIL single_pulse: got %0d pulses ok=%b expected 1 1", en_cnt, width_ok);
        else passes++;
        checks++;
        if ({result_valid, found, busy} !== 3'b100)
            $display("FAIL no_valid_done: got %b expected 100", {result_valid, found, busy});
        else passes++;
        start = 1'b0;
    endtask

    task automatic test_key_base();
        logic [NUM_CH*KEY_W-1:0] exp;
        exp = {24'hC00000, 24'h800000, 24'h400000, 24'h000000};
        checks++;
        if (ch_key_base !== exp) $display("FAIL key_base: got %h expected %h", ch_key_base, exp);
        else passes++;
    endtask

    task automatic test_found_directed();
        logic [DIGITS*5-1:0] exp;
        for (int i = 0; i < NUM_CH; i++) begin
            job_dly[i] = 0;
            job_vld[i] = 1'b0;
            job_key[i] = '0;
        end
        job_dly[1] = 50;
        job_vld[1] = 1'b1;
        job_key[1] = 24'h8A3F01;
        run_job("found_8a3f01");
        exp = {5'd8, 5'd10, 5'd3, 5'd15, 5'd0, 5'd1};
        checks++;
        if (digit_codes !== exp) $display("FAIL digits_8a3f01: got %h expected %h", digit_codes, exp);
        else passes++;
    endtask

    task automatic test_tie_and_none();
        for (int i = 0; i < NUM_CH; i++) begin
            job_dly[i] = 10;
            job_vld[i] = 1'b0;
            job_key[i] = 24'hFFFFFF;
        end
        job_vld[0] = 1'b1;
        job_key[0] = 24'h000123;
        job_vld[1] = 1'b1;
        job_key[1] = 24'h900000;
        run_job("tie_lowest");
        for (int i = 0; i < NUM_CH; i++) begin
            job_dly[i] = 5 + 7 * i;
            job_vld[i] = 1'b0;
        end
        run_job("none_valid");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 18; n++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                job_dly[i] = $urandom_range(1, 12);
                job_vld[i] = ($urandom_range(0, 2) == 0);
                job_key[i] = KEY_W'($urandom);
            end
            run_job($sformatf("rand%0d", n));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b0;
        ch_rdy = '0;
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ch_rdy = '1;
        #1;
        checks++;
        if (ch_en !== '0) $display("FAIL rst_en_gate: got %b expected 0", ch_en);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if ({busy, result_valid, found, result_key, timed_out} !== '0 || digit_codes !== {DIGITS{5'd16}})
            $display("FAIL rst_wait: got busy=%b rv=%b dig=%h expected 0 0 blank", busy, result_valid, digit_codes);
        else passes++;
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        ch_rdy = '0;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("FAIL crack_busy: got %b expected 1", busy);
        else passes++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        ch_rdy = '1;
        #1;
        checks++;
        if ({ch_en, busy, result_valid, found, result_key, timed_out} !== '0 || digit_codes !== {DIGITS{5'd16}})
            $display("FAIL rst_crack: got busy=%b rv=%b f=%b key=%h dig=%h expected reset values",
                     busy, result_valid, found, result_key, digit_codes);
        else passes++;
    endtask

    task automatic test_timeout();
        int done_cyc;
        @(negedge clk);
        start = 1'b0;
        ch_rdy = '1;
        ch_key_valid = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        ch_rdy = '0;
        start = 1'b0;
        done_cyc = 0;
`ifdef CRACK_TIMEOUT_EN
        for (int cyc = 1; cyc <= 300 && done_cyc == 0; cyc++) begin
            @(posedge clk);
            #1;
            if (result_valid) done_cyc = cyc;
        end
        checks++;
        if (done_cyc != TO_CYC + 1) $display("FAIL timeout_latency: got %0d expected %0d", done_cyc, TO_CYC + 1);
        else passes++;
        checks++;
        if ({found, timed_out, busy} !== 3'b010 || digit_codes !== {DIGITS{5'd18}})
            $display("FAIL timeout_flags: got f=%b to=%b b=%b dig=%h expected 0 1 0 all-18",
                     found, timed_out, busy, digit_codes);
        else passes++;
`else
        repeat (150) @(posedge clk);
        #1;
        checks++;
        if ({busy, result_valid, timed_out} !== 3'b100)
            $display("FAIL no_timeout: got b=%b rv=%b to=%b expected 1 0 0", busy, result_valid, timed_out);
        else passes++;
        ch_rdy = '1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({result_valid, found, timed_out} !== 3'b100)
            $display("FAIL no_timeout_done: got %b expected 100", {result_valid, found, timed_out});
        else passes++;
`endif
        @(negedge clk);
        ch_rdy = '1;
    endtask

    initial begin
        test_reset();
        test_key_base();
        test_found_directed();
        test_tie_and_none();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
